// File: rtl/tri_span_walker_if.sv
// Triangle-in / span-out bundle for the scanline walker.
// slave = walker side, master = setup stage plus span consumer side.
interface tri_span_walker_if #(
    parameter int COORD_W = 10,
    parameter int FRAC_W  = 14
);
    localparam int ACC_W = COORD_W + FRAC_W + 2;

    logic                      tri_valid;
    logic                      tri_ready;
    logic [COORD_W-1:0]        v0_x, v0_y;
    logic [COORD_W-1:0]        v1_x, v1_y;
    logic [COORD_W-1:0]        v2_x, v2_y;
    logic signed [ACC_W-1:0]   slope_02, slope_01, slope_12;
    logic                      span_valid;
    logic                      span_ready;
    logic [COORD_W-1:0]        span_y;
    logic [COORD_W-1:0]        span_x_start;
    logic [COORD_W-1:0]        span_x_end;
    logic                      span_last;
    logic                      err;

    modport slave (
        input  tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
               slope_02, slope_01, slope_12, span_ready,
        output tri_ready, span_valid, span_y, span_x_start, span_x_end, span_last, err
    );

    modport master (
        output tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
               slope_02, slope_01, slope_12, span_ready,
        input  tri_ready, span_valid, span_y, span_x_start, span_x_end, span_last, err
    );
endinterface

// File: rtl/tri_span_walker.sv
// Walks one y-sorted triangle a scanline per cycle and streams (y, x_start, x_end) spans.
// First span 2 edges after accept; outputs registered and held while span_ready is low.
module tri_span_walker #(
    parameter int COORD_W = 10,
    parameter int FRAC_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    tri_span_walker_if.slave bus
);
    localparam int ACC_W = COORD_W + FRAC_W + 2;
    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] XMAX =
        {{(ACC_W-COORD_W){1'b0}}, {COORD_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0]      x0_q, x1_q, x2_q, y0_q, y1_q, y2_q;
    logic signed [ACC_W-1:0] s02_q, s01_q, s12_q;
    logic signed [ACC_W-1:0] acc_l, acc_s;
    logic [COORD_W-1:0]      cur_y;

    logic                    out_vld, out_last, err_q;
    logic [COORD_W-1:0]      out_y, out_xs, out_xe;

    logic                    order_ok, accept, hs, flat, load_out;
    logic [COORD_W-1:0]      y_inc, src_y, xa, xb, xmin, xmax;
    logic signed [ACC_W-1:0] l_nxt, s_nxt, src_l, src_s;

    function automatic logic signed [ACC_W-1:0] to_fix(input logic [COORD_W-1:0] x);
        return {{(ACC_W-COORD_W-FRAC_W){1'b0}}, x, {FRAC_W{1'b0}}};
    endfunction

    // Round half up to an integer pixel, then clamp onto the screen.
    function automatic logic [COORD_W-1:0] round_clamp(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + HALF) >>> FRAC_W;
        if (r[ACC_W-1])
            return '0;
        else if (r > XMAX)
            return '1;
        else
            return r[COORD_W-1:0];
    endfunction

    assign order_ok = (bus.v0_y <= bus.v1_y) && (bus.v1_y <= bus.v2_y);
    assign accept   = (state == IDLE) && bus.tri_valid && !abort;
    assign hs       = out_vld && bus.span_ready;
    assign flat     = (y0_q == y2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && order_ok) state_nxt = SETUP;
            SETUP:   state_nxt = EMIT;
            EMIT:    if (hs && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    always_comb begin
        y_inc = cur_y + COORD_W'(1);
        l_nxt = acc_l + s02_q;
        // Reload the short edge at the middle vertex so slope rounding never drifts past it.
        if (y_inc == y1_q)
            s_nxt = to_fix(x1_q);
        else if (y_inc < y1_q)
            s_nxt = acc_s + s01_q;
        else
            s_nxt = acc_s + s12_q;

        load_out = (state == EMIT) && (!out_vld || (bus.span_ready && !out_last));

        if (out_vld) begin
            src_y = y_inc;
            src_l = l_nxt;
            src_s = s_nxt;
        end else begin
            src_y = cur_y;
            src_l = acc_l;
            src_s = acc_s;
        end

        xa   = round_clamp(src_l);
        xb   = round_clamp(src_s);
        xmin = (xa < xb) ? xa : xb;
        xmax = (xa < xb) ? xb : xa;
        if (flat) begin
            xmin = (x0_q < x1_q) ? x0_q : x1_q;
            xmin = (xmin < x2_q) ? xmin : x2_q;
            xmax = (x0_q > x1_q) ? x0_q : x1_q;
            xmax = (xmax > x2_q) ? xmax : x2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q     <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
            s02_q    <= '0;
            s01_q    <= '0;
            s12_q    <= '0;
            acc_l    <= '0;
            acc_s    <= '0;
            cur_y    <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_y    <= '0;
            out_xs   <= '0;
            out_xe   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && !order_ok;
            if (accept && order_ok) begin
                x0_q  <= bus.v0_x;
                x1_q  <= bus.v1_x;
                x2_q  <= bus.v2_x;
                y0_q  <= bus.v0_y;
                y1_q  <= bus.v1_y;
                y2_q  <= bus.v2_y;
                s02_q <= bus.slope_02;
                s01_q <= bus.slope_01;
                s12_q <= bus.slope_12;
            end
            if (abort) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end else begin
                if (state == SETUP) begin
                    cur_y <= y0_q;
                    acc_l <= to_fix(x0_q);
                    acc_s <= to_fix((y0_q == y1_q) ? x1_q : x0_q);
                end
                if (load_out) begin
                    out_vld  <= 1'b1;
                    out_y    <= src_y;
                    out_xs   <= xmin;
                    out_xe   <= xmax;
                    out_last <= (src_y == y2_q);
                end else if (hs) begin
                    out_vld  <= 1'b0;
                    out_last <= 1'b0;
                end
                if (hs && !out_last) begin
                    cur_y <= y_inc;
                    acc_l <= l_nxt;
                    acc_s <= s_nxt;
                end
            end
        end
    end

    assign bus.tri_ready    = (state == IDLE);
    assign bus.span_valid   = out_vld;
    assign bus.span_y       = out_y;
    assign bus.span_x_start = out_xs;
    assign bus.span_x_end   = out_xe;
    assign bus.span_last    = out_last;
    assign bus.err          = err_q;
endmodule
